// File: rtl/f1_pkg.sv
// f1_pkg: shared types and constants for the F1 reaction timer.
package f1_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD,
    S_TIMING,
    S_DONE,
    S_FAULT
  } state_t;

  // Random hold LFSR: 7 bits, x^7 + x^6 + 1 (feedback from bits 6 and 5).
  localparam int                LFSR_W    = 7;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

  // One Fibonacci step: shift left, feed back the XOR of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f1_reaction_timer_if.sv
// f1_reaction_timer_if: tick/lights/start/button inputs and result outputs.
interface f1_reaction_timer_if #(
  parameter int D_WIDTH = 8,
  parameter int T_WIDTH = 16
);
  logic               tick;
  logic [D_WIDTH-1:0] lights;
  logic               start;
  logic               btn;
  logic               go;
  logic [T_WIDTH-1:0] react_time;
  logic               valid;
  logic               false_start;
  logic               timeout;
  logic               busy;

  // Environment side: drives stimulus, observes results.
  modport master (
    output tick, lights, start, btn,
    input  go, react_time, valid, false_start, timeout, busy
  );

  // Timer side.
  modport slave (
    input  tick, lights, start, btn,
    output go, react_time, valid, false_start, timeout, busy
  );
endinterface

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running 7-bit Fibonacci LFSR used to randomise the hold time.
module f1_lfsr
  import f1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] q_q;

  // Advance every clock; a non-zero seed keeps the sequence out of the all-zero lock-up.
  always_ff @(posedge clk) begin
    if (!rst) q_q <= LFSR_SEED;
    else      q_q <= lfsr_next(q_q);
  end

  assign q = q_q;
endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: waits for all start lights, holds a random number of
// ticks, pulses go at lights-out and measures the driver's reaction in ticks.
// Optional feature: define F1_FALSE_START_EN to detect a button press before
// lights-out (ARMED/HOLD) and latch it as a false start in the FAULT state.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int D_WIDTH   = 8,
  parameter int T_WIDTH   = 16,
  parameter int DELAY_MIN = 2
) (
  input logic                clk,
  input logic                rst,
  f1_reaction_timer_if.slave bus
);
  // One extra bit so lfsr + DELAY_MIN cannot wrap.
  localparam int                 HOLD_W = LFSR_W + 1;
  localparam logic [T_WIDTH-1:0] T_MAX  = '1;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [T_WIDTH-1:0] count_q, count_d;
  logic [T_WIDTH-1:0] react_time_q, react_time_d;
  logic               go_q, go_d;
  logic               valid_q, valid_d;
  logic               false_start_q, false_start_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  logic [LFSR_W-1:0]  lfsr_w;
  logic [D_WIDTH-1:0] lights_w;
  logic               lights_full;
  logic               fs_btn;
  logic [HOLD_W-1:0]  hold_load;
  logic [T_WIDTH-1:0] count_inc;

  f1_lfsr u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_w)
  );

  assign lights_w    = bus.lights;
  assign lights_full = &lights_w;
  assign hold_load   = HOLD_W'(lfsr_w) + HOLD_W'(DELAY_MIN);
  // Counter value including a tick on this clock, saturating at all ones.
  assign count_inc   = (bus.tick && (count_q != T_MAX)) ? count_q + T_WIDTH'(1) : count_q;

`ifdef F1_FALSE_START_EN
  assign fs_btn          = bus.btn;
  assign bus.false_start = false_start_q;
`else
  assign fs_btn          = 1'b0;
  assign bus.false_start = 1'b0;
`endif

  // Next-state and next-output logic; results only change on run start or completion.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    count_d       = count_q;
    react_time_d  = react_time_q;
    go_d          = 1'b0;
    valid_d       = valid_q;
    false_start_d = false_start_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_ARMED;
          react_time_d  = '0;
          valid_d       = 1'b0;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_ARMED: begin
        if (fs_btn) begin
          state_d       = S_FAULT;
          false_start_d = 1'b1;
        end else if (lights_full) begin
          state_d    = S_HOLD;
          hold_cnt_d = hold_load;
        end
      end
      S_HOLD: begin
        // Lights are deliberately not re-checked here.
        if (fs_btn) begin
          state_d       = S_FAULT;
          false_start_d = 1'b1;
        end else if (bus.tick) begin
          if (hold_cnt_q == HOLD_W'(1)) begin
            state_d    = S_TIMING;
            go_d       = 1'b1;
            count_d    = '0;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
      end
      S_TIMING: begin
        count_d = count_inc;
        if (bus.btn) begin
          state_d      = S_DONE;
          react_time_d = count_inc;
          valid_d      = 1'b1;
        end else if (bus.tick && (count_q == T_MAX)) begin
          state_d      = S_DONE;
          react_time_d = T_MAX;
          valid_d      = 1'b1;
          timeout_d    = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.start && !bus.btn) begin
          state_d       = S_ARMED;
          react_time_d  = '0;
          valid_d       = 1'b0;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
        end
      end
      S_FAULT: begin
        if (!bus.start && !bus.btn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ARMED) || (state_d == S_HOLD) || (state_d == S_TIMING);
  end

  // State and output registers; reset discards any run in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      hold_cnt_q    <= '0;
      count_q       <= '0;
      react_time_q  <= '0;
      go_q          <= 1'b0;
      valid_q       <= 1'b0;
      false_start_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      count_q       <= count_d;
      react_time_q  <= react_time_d;
      go_q          <= go_d;
      valid_q       <= valid_d;
      false_start_q <= false_start_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.go         = go_q;
  assign bus.react_time = react_time_q;
  assign bus.valid      = valid_q;
  assign bus.timeout    = timeout_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: directed bench for f1_reaction_timer (T_WIDTH 16 and 4).
module tb_f1_reaction_timer;
  import f1_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  f1_reaction_timer_if #(.D_WIDTH(8), .T_WIDTH(16)) bus ();
  f1_reaction_timer_if #(.D_WIDTH(8), .T_WIDTH(4))  bus4 ();

  f1_reaction_timer #(.D_WIDTH(8), .T_WIDTH(16), .DELAY_MIN(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  f1_reaction_timer #(.D_WIDTH(8), .T_WIDTH(4), .DELAY_MIN(2)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int go_cnt   = 0;
  int go4_cnt  = 0;
  int go_tick  = -1;
  logic [6:0] lfsr_m;
  int exp_rt_q[$];
  bit exp_to_q[$];

  // Reference LFSR: x^7 + x^6 + 1, seed 1.
  always @(posedge clk) begin
    if (!rst) lfsr_m <= 7'h01;
    else      lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  // Count go pulses and record which tick produced them.
  always @(negedge clk) begin
    if (bus.go === 1'b1) begin
      go_cnt  <= go_cnt + 1;
      go_tick <= tick_cnt;
    end
    if (bus4.go === 1'b1) go4_cnt <= go4_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.tick  = 1'b1;
    bus4.tick = 1'b1;
    tick_cnt++;
    cyc();
    bus.tick  = 1'b0;
    bus4.tick = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  // Start a run, present all-ones lights two clocks later, return lfsr at HOLD entry.
  task automatic arm(input string tag, output logic [6:0] l);
    bus.start = 1'b1;
    cyc();
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_valid_clr"}, bus.valid, 0);
    chk({tag, "_react_clr"}, bus.react_time, 0);
    chk({tag, "_fs_clr"}, bus.false_start, 0);
    bus.start = 1'b0;
    cyc();
    chk({tag, "_armed"}, dut.state_q, S_ARMED);
    chk({tag, "_lfsr_track"}, dut.u_lfsr.q, lfsr_m);
    bus.lights = 8'hFF;
    l = lfsr_m;
    cyc();
    bus.lights = 8'h00;
    tick_cnt = 0;
    cyc();
    chk({tag, "_hold_lights_drop"}, dut.state_q, S_HOLD);
  endtask

  task automatic wait_go(input string tag, input logic [6:0] l);
    int g0 = go_cnt;
    int n = 0;
    while (go_cnt == g0 && n < 300) begin
      tick_once();
      n++;
    end
    chk({tag, "_go_pulses"}, go_cnt - g0, 1);
    chk({tag, "_go_ticks"}, go_tick, int'(l) + 2);
    chk({tag, "_timing"}, dut.state_q, S_TIMING);
  endtask

  task automatic press(input string tag, input int exp_rt);
    int n = 0;
    exp_rt_q.push_back(exp_rt);
    exp_to_q.push_back(1'b0);
    bus.tick = 1'b1;
    bus.btn  = 1'b1;
    cyc();
    bus.tick = 1'b0;
    bus.btn  = 1'b0;
    while (bus.valid !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk({tag, "_valid"}, bus.valid, 1);
    chk({tag, "_sb_depth"}, exp_rt_q.size(), 1);
    if (exp_rt_q.size() > 0) begin
      chk({tag, "_react"}, bus.react_time, exp_rt_q.pop_front());
      chk({tag, "_timeout"}, bus.timeout, exp_to_q.pop_front());
    end
    chk({tag, "_done"}, dut.state_q, S_DONE);
    chk({tag, "_busy_low"}, bus.busy, 0);
  endtask

  initial begin
    logic [6:0] l;
    int g0;
    int n;
    bus.tick = 0; bus.lights = '0; bus.start = 0; bus.btn = 0;
    bus4.tick = 0; bus4.lights = '0; bus4.start = 0; bus4.btn = 0;

    // Reset state.
    cyc();
    cyc();
    chk("rst_go", bus.go, 0);
    chk("rst_react", bus.react_time, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_fs", bus.false_start, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", dut.state_q, S_IDLE);
    chk("rst_lfsr", dut.u_lfsr.q, 7'h01);
    chk("rst4_state", dut4.state_q, S_IDLE);
    rst = 1'b1;

    // Full run: press on the 250th tick after go.
    arm("s1", l);
    wait_go("s1", l);
    tick_n(249);
    press("s1", 250);
    cyc(); cyc(); cyc();
    chk("s1_react_held", bus.react_time, 250);

    // Press coinciding with the tick that takes the counter from 9 to 10.
    arm("s2", l);
    wait_go("s2", l);
    tick_n(9);
    press("s2", 10);

    // 4-bit counter saturates, next tick is a timeout.
    bus4.start = 1'b1;
    cyc();
    bus4.start = 1'b0;
    bus4.lights = 8'hFF;
    cyc();
    bus4.lights = 8'h00;
    g0 = go4_cnt;
    n = 0;
    while (go4_cnt == g0 && n < 300) begin
      tick_once();
      n++;
    end
    chk("t4_go_pulses", go4_cnt - g0, 1);
    tick_n(15);
    chk("t4_valid_before", bus4.valid, 0);
    chk("t4_timing", dut4.state_q, S_TIMING);
    exp_rt_q.push_back(15);
    exp_to_q.push_back(1'b1);
    tick_once();
    chk("t4_valid", bus4.valid, 1);
    chk("t4_sb_depth", exp_rt_q.size(), 1);
    if (exp_rt_q.size() > 0) begin
      chk("t4_react", bus4.react_time, exp_rt_q.pop_front());
      chk("t4_timeout", bus4.timeout, exp_to_q.pop_front());
    end

    // Button during HOLD.
    arm("s4", l);
    tick_n(2);
    bus.btn = 1'b1;
    cyc();
    bus.btn = 1'b0;
`ifdef F1_FALSE_START_EN
    chk("s4_fs", bus.false_start, 1);
    chk("s4_fault", dut.state_q, S_FAULT);
    chk("s4_busy", bus.busy, 0);
    cyc();
    chk("s4_idle", dut.state_q, S_IDLE);
    g0 = go_cnt;
    tick_n(140);
    chk("s4_no_go", go_cnt - g0, 0);
    chk("s4_no_valid", bus.valid, 0);
    chk("s4_fs_held", bus.false_start, 1);
`else
    chk("s4_fs_tied", bus.false_start, 0);
    chk("s4_still_hold", dut.state_q, S_HOLD);
    wait_go("s4", l);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
`endif

    // Reset for one clock in TIMING.
    arm("s5", l);
    wait_go("s5", l);
    tick_n(5);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("s5_go", bus.go, 0);
    chk("s5_react", bus.react_time, 0);
    chk("s5_valid", bus.valid, 0);
    chk("s5_fs", bus.false_start, 0);
    chk("s5_timeout", bus.timeout, 0);
    chk("s5_busy", bus.busy, 0);
    chk("s5_state", dut.state_q, S_IDLE);
    chk("s5_lfsr", dut.u_lfsr.q, 7'h01);
    g0 = go_cnt;
    tick_n(140);
    chk("s5_no_go", go_cnt - g0, 0);
    chk("s5_idle_after", dut.state_q, S_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameters SHALL be D_WIDTH (default 8, lights bus width), T_WIDTH (default 16, reaction counter width) and DELAY_MIN (default 2, minimum hold in ticks).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset: sampled only on the clk rising edge, and asserted when low.
REQ-004 tick  input  1  one-clk strobe, nominally 1 ms, from the upstream tick divider.
REQ-005 lights  input  D_WIDTH  start-light pattern from the upstream light sequencer.
REQ-006 start  input  1  level; arms a new run.
REQ-007 btn  input  1  driver button, already synchronised, active-high.
REQ-008 go  output  1  one-clk pulse marking lights-out (timing origin).
REQ-009 react_time  output  T_WIDTH  measured reaction in ticks; held until next run.
REQ-010 valid  output  1  high while react_time holds a result.
REQ-011 false_start  output  1  high while a false start is latched.
REQ-012 timeout  output  1  high while a saturated (no-press) result is latched.
REQ-013 busy  output  1  high in ARMED, HOLD and TIMING.

Function
REQ-014 FSM states SHALL be IDLE, ARMED, HOLD, TIMING, DONE and FAULT.
REQ-015 IDLE->ARMED when start=1; the pending result and all result flags clear on that same edge.
REQ-016 ARMED->HOLD on the first clk where lights == all ones; hold_cnt loads lfsr[6:0] + DELAY_MIN on that edge.
REQ-017 HOLD: hold_cnt decrements on each tick; when hold_cnt == 1 and tick = 1, go is pulsed on the next clk, the state goes to TIMING, and the reaction counter clears to 0.
REQ-018 TIMING: the counter increments on each tick; on the first clk with btn = 1, react_time takes the counter value, valid = 1, and the state goes to DONE. A tick and btn on the same clk count that tick.
REQ-019 The counter SHALL saturate at all ones. If it is saturated and a further tick arrives, react_time = all ones, timeout = 1, valid = 1, and the state goes to DONE.
REQ-020 DONE->ARMED when start = 1 and btn = 0; otherwise the state holds DONE.
REQ-021 FAULT->IDLE when start = 0 and btn = 0; false_start stays set until the next start.
REQ-022 lfsr: 7-bit Fibonacci LFSR, taps x^7 + x^6 + 1, advancing on every clk, seed 7'h01 on reset, never zero.
REQ-023 If lights leave all ones during HOLD, the state SHALL stay HOLD (the sequencer is not re-checked).
REQ-024 There SHALL be no combinational path from btn to any output; all outputs are registered.

Reset
REQ-025 On a clk edge with rst = 0, the block SHALL go to state IDLE, set lfsr = 7'h01, and clear hold_cnt, the counter, react_time, go, valid, false_start, timeout and busy to 0, overriding every other input.
REQ-026 Reset mid-run (HOLD or TIMING) SHALL discard the run; go SHALL NOT be pulsed afterwards.

Configuration
REQ-027 With F1_FALSE_START_EN defined, btn = 1 in ARMED or HOLD SHALL set false_start = 1 and move the state to FAULT on the next edge. A FAULT run never asserts go or valid.
REQ-028 Without F1_FALSE_START_EN, btn SHALL be ignored outside TIMING, the FAULT state SHALL be unreachable, and false_start SHALL be tied to 0.

Structure
REQ-029 Package f1_pkg SHALL hold the state enum, the LFSR width, the tap constant and the LFSR seed.
REQ-030 The LFSR SHALL be the sub-module f1_lfsr (ports clk, rst, q[6:0]). The FSM, counters and output registers SHALL reside in f1_reaction_timer.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Reset, start = 1, lights = 0xFF two clks later, btn at the 250th tick after go -> react_time = 250, valid = 1, timeout = 0.
- With DELAY_MIN = 2 and a known lfsr value at HOLD entry -> go arrives after exactly lfsr + 2 ticks.
- F1_FALSE_START_EN defined, btn = 1 during HOLD -> false_start = 1 and state FAULT; go never pulses.
- T_WIDTH = 4 and no btn -> react_time = 4'hF, timeout = 1 and valid = 1 after 16 ticks in TIMING.
- rst = 0 for one clk during TIMING -> all outputs 0, state IDLE, lfsr = 7'h01.
- btn coincident with a tick at a counter value of 9 -> react_time = 10.
